rtc_prog_writer: RTL and testbench



---
 rtl/rtc_pkg.sv | 74 +++++++
 rtl/rtc_phase_timer.sv | 29 ++
 rtl/rtc_prog_writer.sv | 159 +++++++++++++++
 tb/tb_rtc_prog_writer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants for the RTC programming path: register map, job ids,
// writer FSM state codes and the registered bus bundle.
package rtc_pkg;

  localparam logic [7:0] REG_SEG      = 8'h21;
  localparam logic [7:0] REG_MIN      = 8'h22;
  localparam logic [7:0] REG_HOR      = 8'h23;
  localparam logic [7:0] REG_DIA      = 8'h24;
  localparam logic [7:0] REG_MES      = 8'h25;
  localparam logic [7:0] REG_ANIO     = 8'h26;
  localparam logic [7:0] REG_TSEG     = 8'h41;
  localparam logic [7:0] REG_TMIN     = 8'h42;
  localparam logic [7:0] REG_THOR     = 8'h43;
  localparam logic [7:0] CMD_XFER_RTC = 8'hF1;
  localparam logic [7:0] CMD_XFER_TMR = 8'hF2;

  // Same encoding the control FSM drives on C_Sel_Progra.
  localparam logic [1:0] JOB_NONE = 2'b00;
  localparam logic [1:0] JOB_CLK  = 2'b01;
  localparam logic [1:0] JOB_DATE = 2'b10;
  localparam logic [1:0] JOB_TMR  = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_GAP1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_GAP2 = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] ad;
    logic       ad_oe;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs_n: 1'b1, wr_n: 1'b1, a_d: 1'b1, ad: 8'h00, ad_oe: 1'b0};

  // Register address for transaction txn of a job; txn 3 is the transfer command.
  function automatic logic [7:0] reg_addr(input logic [1:0] job, input logic [1:0] txn);
    logic [7:0] a;
    a = 8'h00;
    case (job)
      JOB_CLK: begin
        case (txn)
          2'd0:    a = REG_SEG;
          2'd1:    a = REG_MIN;
          2'd2:    a = REG_HOR;
          default: a = CMD_XFER_RTC;
        endcase
      end
      JOB_DATE: begin
        case (txn)
          2'd0:    a = REG_DIA;
          2'd1:    a = REG_MES;
          2'd2:    a = REG_ANIO;
          default: a = CMD_XFER_RTC;
        endcase
      end
      JOB_TMR: begin
        case (txn)
          2'd0:    a = REG_TSEG;
          2'd1:    a = REG_TMIN;
          2'd2:    a = REG_THOR;
          default: a = CMD_XFER_TMR;
        endcase
      end
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus phase timer: reloads with PHASE_CYC-1 and pulses phase_end on the
// last cycle of every phase while run is high.
module rtc_phase_timer #(
  parameter int PHASE_CYC = 10
) (
  input  logic Clock,
  input  logic Reset,
  input  logic load,
  input  logic run,
  output logic phase_end
);

  localparam int CW = $clog2(PHASE_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(PHASE_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset)
      cnt_q <= '0;
    else if (load || (run && cnt_q == '0))
      cnt_q <= LOAD_VAL;
    else if (run)
      cnt_q <= cnt_q - 1'b1;
  end

  assign phase_end = run && (cnt_q == '0);

endmodule

// File: rtl/rtc_prog_writer.sv
// Writes a latched 3-byte BCD job plus a transfer command to the RTC over its
// multiplexed address/data bus, then completes a four-phase done handshake.
module rtc_prog_writer
  import rtc_pkg::*;
#(
  parameter int PHASE_CYC = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Ini_PR,
  input  logic       Ini_PF,
  input  logic       Ini_PT,
  input  logic [7:0] Seg,
  input  logic [7:0] Min,
  input  logic [7:0] Hor,
  input  logic [7:0] Dia,
  input  logic [7:0] Mes,
  input  logic [7:0] Anio,
  input  logic [7:0] T_Seg,
  input  logic [7:0] T_Min,
  input  logic [7:0] T_Hor,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       Busy,
  output logic       L_Re,
  output logic       L_Fe,
  output logic       L_Ti
);

  logic [2:0]      state_q, state_d;
  logic [1:0]      job_q;
  logic [1:0]      txn_q;
  logic [2:0][7:0] bytes_q;
  logic [1:0]      start_job;
  logic            job_lvl;
  logic            load, run, phase_end;
  logic [7:0]      cur_addr, cur_data;
  bus_t            bus_q, bus_d;
  logic            busy_d;
  logic [2:0]      flags_q, flags_d;

  always_comb begin
    start_job = JOB_NONE;
    if (Ini_PR)      start_job = JOB_CLK;
    else if (Ini_PF) start_job = JOB_DATE;
    else if (Ini_PT) start_job = JOB_TMR;
  end

  // Only the latched job's own start line can close the handshake.
  always_comb begin
    job_lvl = 1'b0;
    case (job_q)
      JOB_CLK:  job_lvl = Ini_PR;
      JOB_DATE: job_lvl = Ini_PF;
      JOB_TMR:  job_lvl = Ini_PT;
      default:  job_lvl = 1'b0;
    endcase
  end

  assign load = (state_q == ST_IDLE) && (start_job != JOB_NONE);
  assign run  = (state_q == ST_ADDR) || (state_q == ST_GAP1) ||
                (state_q == ST_DATA) || (state_q == ST_GAP2);

  rtc_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (load),
    .run       (run),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load)      state_d = ST_ADDR;
      ST_ADDR: if (phase_end) state_d = ST_GAP1;
      ST_GAP1: if (phase_end) state_d = ST_DATA;
      ST_DATA: if (phase_end) state_d = ST_GAP2;
      ST_GAP2: if (phase_end) state_d = (txn_q == 2'd3) ? ST_DONE : ST_ADDR;
      ST_DONE: if (!job_lvl)  state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_addr = reg_addr(job_q, txn_q);
    case (txn_q)
      2'd0:    cur_data = bytes_q[0];
      2'd1:    cur_data = bytes_q[1];
      2'd2:    cur_data = bytes_q[2];
      default: cur_data = 8'h00;
    endcase
  end

  // Outputs are registered from the current state, so the bus trails the FSM by one cycle.
  always_comb begin
    bus_d = BUS_IDLE;
    case (state_q)
      ST_ADDR: bus_d = '{cs_n: 1'b0, wr_n: 1'b0, a_d: 1'b0, ad: cur_addr, ad_oe: 1'b1};
      ST_GAP1: bus_d = '{cs_n: 1'b1, wr_n: 1'b1, a_d: 1'b0, ad: cur_addr, ad_oe: 1'b1};
      ST_DATA: bus_d = '{cs_n: 1'b0, wr_n: 1'b0, a_d: 1'b1, ad: cur_data, ad_oe: 1'b1};
      ST_GAP2: bus_d = '{cs_n: 1'b1, wr_n: 1'b1, a_d: 1'b1, ad: cur_data, ad_oe: 1'b1};
      default: bus_d = BUS_IDLE;
    endcase
    busy_d  = load || run;
    flags_d = 3'b000;
    if (state_q == ST_DONE) begin
      case (job_q)
        JOB_CLK:  flags_d = 3'b100;
        JOB_DATE: flags_d = 3'b010;
        JOB_TMR:  flags_d = 3'b001;
        default:  flags_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      job_q   <= JOB_NONE;
      txn_q   <= 2'd0;
      bytes_q <= '0;
      bus_q   <= BUS_IDLE;
      Busy    <= 1'b0;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      Busy    <= busy_d;
      flags_q <= flags_d;
      if (load) begin
        job_q <= start_job;
        txn_q <= 2'd0;
        case (start_job)
          JOB_CLK:  bytes_q <= {Hor, Min, Seg};
          JOB_DATE: bytes_q <= {Anio, Mes, Dia};
          default:  bytes_q <= {T_Hor, T_Min, T_Seg};
        endcase
      end else if (state_q == ST_GAP2 && phase_end && txn_q != 2'd3) begin
        txn_q <= txn_q + 2'd1;
      end
    end
  end

  assign CS_n   = bus_q.cs_n;
  assign RD_n   = 1'b1;
  assign WR_n   = bus_q.wr_n;
  assign A_D    = bus_q.a_d;
  assign AD_out = bus_q.ad;
  assign AD_oe  = bus_q.ad_oe;
  assign L_Re   = flags_q[2];
  assign L_Fe   = flags_q[1];
  assign L_Ti   = flags_q[0];

endmodule

// File: tb/tb_rtc_prog_writer.sv
// Directed bench for rtc_prog_writer: one instance with PHASE_CYC=2 and one
// with PHASE_CYC=1, driven from a job table plus reset corner sequences.
module tb_rtc_prog_writer;

  logic Clock = 1'b0;
  logic Reset;
  logic pr0, pf0, pt0, pr1, pf1, pt1;
  logic [7:0] Seg, Min, Hor, Dia, Mes, Anio, T_Seg, T_Min, T_Hor;

  logic cs0, rd0, wr0, ad0, oe0, busy0, re0, fe0, ti0;
  logic cs1, rd1, wr1, ad1, oe1, busy1, re1, fe1, ti1;
  logic [7:0] out0, out1;

  always #5 Clock = ~Clock;

  rtc_prog_writer #(.PHASE_CYC(2)) dut (
    .Clock(Clock), .Reset(Reset), .Ini_PR(pr0), .Ini_PF(pf0), .Ini_PT(pt0),
    .Seg(Seg), .Min(Min), .Hor(Hor), .Dia(Dia), .Mes(Mes), .Anio(Anio),
    .T_Seg(T_Seg), .T_Min(T_Min), .T_Hor(T_Hor),
    .CS_n(cs0), .RD_n(rd0), .WR_n(wr0), .A_D(ad0), .AD_out(out0), .AD_oe(oe0),
    .Busy(busy0), .L_Re(re0), .L_Fe(fe0), .L_Ti(ti0)
  );

  rtc_prog_writer #(.PHASE_CYC(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Ini_PR(pr1), .Ini_PF(pf1), .Ini_PT(pt1),
    .Seg(Seg), .Min(Min), .Hor(Hor), .Dia(Dia), .Mes(Mes), .Anio(Anio),
    .T_Seg(T_Seg), .T_Min(T_Min), .T_Hor(T_Hor),
    .CS_n(cs1), .RD_n(rd1), .WR_n(wr1), .A_D(ad1), .AD_out(out1), .AD_oe(oe1),
    .Busy(busy1), .L_Re(re1), .L_Fe(fe1), .L_Ti(ti1)
  );

  // Bytes packed as {T_Hor,T_Min,T_Seg,Anio,Mes,Dia,Hor,Min,Seg}; ea/ed as {t3,t2,t1,t0}.
  typedef struct {
    int          inst;
    logic [2:0]  start;
    logic [71:0] bytes;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [2:0]  eflag;
    bit          early;
  } vec_t;

  localparam logic [16:0] M_ALL  = 17'h1FFFF;
  localparam logic [16:0] M_GAP2 = 17'h1E01F;
  localparam logic [16:0] M_DONE = 17'h0801F;
  localparam logic [16:0] RST_V  = 17'h1E000;

  vec_t vecs[6];
  int n_chk = 0;
  int n_fail = 0;

  // {CS_n,RD_n,WR_n,A_D,AD_out,AD_oe,Busy,L_Re,L_Fe,L_Ti}
  function automatic logic [16:0] obs(input int inst);
    if (inst == 0) return {cs0, rd0, wr0, ad0, out0, oe0, busy0, re0, fe0, ti0};
    return {cs1, rd1, wr1, ad1, out1, oe1, busy1, re1, fe1, ti1};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp, input logic [16:0] m);
    n_chk++;
    if ((act & m) !== (exp & m)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act & m, exp & m, m);
    end
  endtask

  task automatic set_bytes(input logic [71:0] b);
    {T_Hor, T_Min, T_Seg, Anio, Mes, Dia, Hor, Min, Seg} = b;
  endtask

  task automatic set_start(input int inst, input logic [2:0] s);
    if (inst == 0) {pr0, pf0, pt0} = s;
    else           {pr1, pf1, pt1} = s;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int P, ph, t, p;
    logic [16:0] e, m, fin;
    P = (v.inst == 0) ? 2 : 1;
    set_bytes(v.bytes);
    set_start(v.inst, v.start);
    @(posedge Clock);  // E0
    for (int k = 1; k <= 16 * P; k++) begin
      @(posedge Clock); #1;
      ph = (k - 1) / P;
      t  = ph / 4;
      p  = ph % 4;
      e  = {(p == 1 || p == 3), 1'b1, (p == 1 || p == 3), (p >= 2),
            (p < 2) ? v.ea[8*t +: 8] : v.ed[8*t +: 8], 1'b1, 1'b1, 3'b000};
      m  = (p == 3) ? M_GAP2 : M_ALL;
      check($sformatf("%s cyc%0d", tag, k), obs(v.inst), e, m);
      if (k == 3) set_bytes({9{8'h99}});
      if (v.early && k == 16 * P) set_start(v.inst, 3'b000);
    end
    fin = {4'b1111, 8'h00, 1'b0, 1'b0, v.eflag};
    @(posedge Clock); #1;
    check({tag, " done"}, obs(v.inst), fin, M_DONE);
    if (!v.early) begin
      repeat (2) begin
        @(posedge Clock); #1;
        check({tag, " hold"}, obs(v.inst), fin, M_DONE);
      end
      set_start(v.inst, 3'b000);
      @(posedge Clock); #1;
      check({tag, " drop"}, obs(v.inst), fin, M_DONE);
    end
    @(posedge Clock); #1;
    check({tag, " clear"}, obs(v.inst), {4'b1111, 8'h00, 5'b00000}, M_DONE);
  endtask

  initial begin
    vecs[0] = '{0, 3'b100, {8'h03, 8'h20, 8'h10, 8'h24, 8'h11, 8'h07, 8'h12, 8'h30, 8'h45},
                {8'hF1, 8'h23, 8'h22, 8'h21}, {8'h00, 8'h12, 8'h30, 8'h45}, 3'b100, 1'b0};
    vecs[1] = '{0, 3'b011, {8'h03, 8'h20, 8'h10, 8'h24, 8'h11, 8'h07, 8'h12, 8'h30, 8'h45},
                {8'hF1, 8'h26, 8'h25, 8'h24}, {8'h00, 8'h24, 8'h11, 8'h07}, 3'b010, 1'b0};
    vecs[2] = '{0, 3'b001, {8'h03, 8'h20, 8'h10, 8'h24, 8'h11, 8'h07, 8'h12, 8'h30, 8'h45},
                {8'hF2, 8'h43, 8'h42, 8'h41}, {8'h00, 8'h03, 8'h20, 8'h10}, 3'b001, 1'b0};
    vecs[3] = '{0, 3'b111, {8'h23, 8'h59, 8'h01, 8'h31, 8'h12, 8'h28, 8'h23, 8'h59, 8'h58},
                {8'hF1, 8'h23, 8'h22, 8'h21}, {8'h00, 8'h23, 8'h59, 8'h58}, 3'b100, 1'b1};
    vecs[4] = '{1, 3'b010, {8'h23, 8'h59, 8'h01, 8'h31, 8'h12, 8'h28, 8'h23, 8'h59, 8'h58},
                {8'hF1, 8'h26, 8'h25, 8'h24}, {8'h00, 8'h31, 8'h12, 8'h28}, 3'b010, 1'b1};
    vecs[5] = '{1, 3'b001, {8'h23, 8'h59, 8'h01, 8'h31, 8'h12, 8'h28, 8'h23, 8'h59, 8'h58},
                {8'hF2, 8'h43, 8'h42, 8'h41}, {8'h00, 8'h23, 8'h59, 8'h01}, 3'b001, 1'b0};

    Reset = 1'b1;
    set_start(0, 3'b000);
    set_start(1, 3'b000);
    set_bytes('0);
    repeat (3) @(posedge Clock);
    #1;
    check("reset dut", obs(0), RST_V, M_ALL);
    check("reset dut1", obs(1), RST_V, M_ALL);
    Reset = 1'b0;
    @(posedge Clock); #1;

    for (int i = 0; i < 6; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Reset landing in the second DATA phase (cycles 13..14 after E0).
    set_bytes(vecs[0].bytes);
    set_start(0, 3'b100);
    @(posedge Clock);
    repeat (13) @(posedge Clock);
    #1;
    check("pre-reset data", obs(0), {1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 1'b1, 1'b1, 3'b000}, M_ALL);
    Reset = 1'b1;
    set_start(0, 3'b000);
    @(posedge Clock); #1;
    check("mid-job reset", obs(0), RST_V, M_ALL);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("post-reset idle", obs(0), RST_V, M_ALL);
    run_job(vecs[0], "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
